// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with credit-based request issue and redirect flush
//
// Purpose:
//   Issues sequential word-aligned fetch requests to instruction memory,
//   captures in-order responses into a small circular queue and presents the
//   head entry to the decode stage. A redirect flushes the queue, restarts
//   fetch at the new address and marks every in-flight response as stale.
//
// Ports:
//   clk             in   1   clock, all state updates on rising edge
//   reset           in   1   synchronous, active-low
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out  32  fetch address (word aligned)
//   imem_req_ready  in   1   memory accepts the request this cycle
//   imem_resp_valid in   1   in-order response valid
//   imem_resp_data  in   32  fetched instruction word
//   redirect_valid  in   1   control-flow change from a later stage
//   redirect_pc     in   32  new fetch address (low two bits ignored)
//   stall           in   1   decode holds, head is not consumed
//   inst_valid      out  1   head entry valid
//   inst            out  32  head instruction
//   inst_pc         out  32  address of head instruction

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic          credit_ok;
  logic          req_fire;
  logic          resp_ok;
  logic          push;
  logic          discard;
  logic          pop;
  logic [31:0]   redirect_aligned;
  logic          unused_redirect_bits;

  // Queued entries plus in-flight requests never exceed DEPTH, so every
  // response that returns is guaranteed a free slot.
  assign credit_ok = ((CW+1)'(count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);

  assign imem_req_valid = credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = imem_resp_valid && (outstanding != '0);

  // Responses in the redirect cycle are discarded regardless of drop.
  assign push    = resp_ok && !redirect_valid && (drop == '0);
  assign discard = resp_ok && !redirect_valid && (drop != '0);

  assign inst_valid = (count != '0);
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];

  assign pop = inst_valid && !stall && !redirect_valid;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      resp_pc  <= redirect_aligned;
      tail     <= head;
      count    <= '0;
      // Every request still in flight after this cycle returns stale data,
      // so the drop count becomes exactly the remaining outstanding count.
      outstanding <= outstanding - CW'(resp_ok);
      drop        <= outstanding - CW'(resp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
      if (discard) begin
        drop <= drop - CW'(1);
      end
      if (push) begin
        tail    <= tail + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage carries no reset; contents are only observed while the
  // corresponding slot is counted as valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed self-checking bench for fetch_queue

module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // memory / in-flight model: one entry per accepted request, in order
  logic [31:0] mem_addr [$];
  int          mem_due  [$];
  bit          mem_live [$];
  // expected queue contents as seen by decode
  logic [31:0] fq_pc   [$];
  logic [31:0] fq_inst [$];
  logic [31:0] m_fetch_pc;
  bit          known     = 0;
  bit          rand_mode = 0;
  int          lat_lo    = 1;
  int          lat_hi    = 1;

  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h9e37_79b9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit rdy, input bit rst_n);
    bit          resp_real, exp_rv, fire, pop_now, live;
    logic [31:0] a;
    @(negedge clk);
    reset          = rst_n;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    resp_real       = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_addr.size() > 0) begin
      if (mem_due[0] <= cyc && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        resp_real       = 1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr[0]);
      end
    end else if (rand_mode && $urandom_range(0, 15) == 0) begin
      imem_resp_valid = 1'b1;
    end
    #1;
    obs_rv   = imem_req_valid;
    obs_iv   = inst_valid;
    obs_addr = imem_req_addr;
    obs_pc   = inst_pc;
    exp_rv   = !rd && (fq_pc.size() + mem_addr.size() < DEPTH);
    if (known) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("inst_valid", 32'(inst_valid), 32'(fq_pc.size() != 0));
      if (fq_pc.size() != 0) begin
        chk("inst_pc", inst_pc, fq_pc[0]);
        chk("inst", inst, fq_inst[0]);
      end
    end
    fire = exp_rv && rdy;
    if (!rst_n) begin
      mem_addr.delete(); mem_due.delete(); mem_live.delete();
      fq_pc.delete(); fq_inst.delete();
      m_fetch_pc = RESET_PC;
      known      = 1;
    end else begin
      pop_now = (fq_pc.size() != 0) && !st && !rd;
      if (resp_real) begin
        a = mem_addr.pop_front();
        void'(mem_due.pop_front());
        live = mem_live.pop_front();
        if (live && !rd) begin
          fq_pc.push_back(a);
          fq_inst.push_back(mem_word(a));
        end
      end
      if (pop_now) begin
        void'(fq_pc.pop_front());
        void'(fq_inst.pop_front());
      end
      if (rd) begin
        fq_pc.delete(); fq_inst.delete();
        foreach (mem_live[i]) mem_live[i] = 0;
        m_fetch_pc = {rpc[31:2], 2'b00};
      end else if (fire) begin
        mem_addr.push_back(m_fetch_pc);
        mem_due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
        mem_live.push_back(1);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic nstep(input bit st);
    step(st, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    int fires;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    do_reset();
    do_reset();

    // reset state and streaming
    lat_lo = 1; lat_hi = 1;
    nstep(0);
    chk("rst_req_valid", 32'(obs_rv), 32'd1);
    chk("rst_req_addr", obs_addr, RESET_PC);
    chk("rst_inst_valid", 32'(obs_iv), 32'd0);
    found = 0;
    for (int n = 0; n < 8; n++) begin
      nstep(0);
      if (obs_iv) begin found = 1; break; end
    end
    chk("stream_start", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_iv", 32'(obs_iv), 32'd1);
      chk("stream_pc", obs_pc, RESET_PC + 32'(4 * i));
      nstep(0);
    end

    // back-pressure
    do_reset();
    fires = 0;
    for (int n = 0; n < 10; n++) begin
      nstep(1);
      if (obs_rv) fires++;
    end
    chk("bp_reqs", 32'(fires), 32'(DEPTH));
    chk("bp_req_valid", 32'(obs_rv), 32'd0);
    chk("bp_inst_valid", 32'(obs_iv), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nstep(0);
      chk("bp_iv", 32'(obs_iv), 32'd1);
      chk("bp_pc", obs_pc, RESET_PC + 32'(4 * i));
    end

    // redirect with two requests in flight
    do_reset();
    lat_lo = 6; lat_hi = 6;
    nstep(0);
    nstep(0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    chk("rd_req_valid", 32'(obs_rv), 32'd0);
    nstep(0);
    chk("rd_next_addr", obs_addr, 32'h100);
    chk("rd_next_valid", 32'(obs_rv), 32'd1);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      nstep(0);
      if (obs_iv) begin found = 1; break; end
    end
    chk("rd_found", 32'(found), 32'd1);
    chk("rd_first_pc", obs_pc, 32'h100);

    // redirect, response and pop in the same cycle
    do_reset();
    lat_lo = 2; lat_hi = 2;
    for (int n = 0; n < 8; n++) nstep(0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    chk("sim_pre_iv", 32'(obs_iv), 32'd1);
    nstep(0);
    chk("sim_flushed", 32'(obs_iv), 32'd0);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      nstep(0);
      if (obs_iv) begin found = 1; break; end
    end
    chk("sim_found", 32'(found), 32'd1);
    chk("sim_first_pc", obs_pc, 32'h40);

    // misaligned redirect and address wrap
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
    nstep(0);
    chk("mis_addr", obs_addr, 32'h200);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    nstep(0);
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    nstep(0);
    chk("wrap_addr1", obs_addr, 32'h0);

    // reset with filled queue and requests in flight
    do_reset();
    lat_lo = 8; lat_hi = 8;
    for (int n = 0; n < 10; n++) nstep(1);
    chk("mid_pre_iv", 32'(obs_iv), 32'd1);
    do_reset();
    nstep(0);
    chk("mid_inst_valid", 32'(obs_iv), 32'd0);
    chk("mid_req_addr", obs_addr, RESET_PC);
    chk("mid_req_valid", 32'(obs_rv), 32'd1);
    found = 0;
    for (int n = 0; n < 30; n++) begin
      nstep(0);
      if (obs_iv) begin found = 1; break; end
    end
    chk("mid_found", 32'(found), 32'd1);
    chk("mid_first_pc", obs_pc, RESET_PC);

    // randomized traffic
    rand_mode = 1;
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 3,
           rpc,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 199) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
